score_bcd_converter: RTL and testbench



---
 rtl/snake_pkg.sv | 25 ++
 rtl/bcd_digit_adjust.sv | 16 +
 rtl/score_bcd_converter.sv | 174 +++++++++++++++++
 tb/tb_score_bcd_converter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared parameters and the converter state encoding for the snake game display path.
package snake_pkg;

  localparam int SCORE_WIDTH = 16;
  localparam int BCD_DIGITS  = 4;

  // 10**n evaluated at elaboration time, used to size the clamp value
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

  localparam longint unsigned BCD_MAX = pow10(BCD_DIGITS) - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_e;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust (
  input  logic [3:0] i_Digit,
  output logic [3:0] o_Digit
);

  // add-3 correction
  always_comb begin
    o_Digit = i_Digit;
    if (i_Digit >= 4'd5) begin
      o_Digit = i_Digit + 4'd3;
    end
  end

endmodule

// File: rtl/score_bcd_converter.sv
// Iterative binary-to-BCD converter between the game score and the scoreboard.
// One shift per clock, one-deep pending buffer, clamps scores above the
// displayable maximum and reports the clamp on o_Overflow.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | nothing in flight; i_Valid loads the shift register
//   ST_SHIFT | adjust-and-shift, one bit per edge, SCORE_WIDTH edges
//   ST_DONE  | publish result; chain into the next conversion if a source exists
module score_bcd_converter
  import snake_pkg::*;
#(
  parameter int SCORE_WIDTH = snake_pkg::SCORE_WIDTH,
  parameter int DIGITS      = snake_pkg::BCD_DIGITS
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic [SCORE_WIDTH-1:0] i_Score,
  input  logic                   i_Valid,
  output logic                   o_Ready,
  output logic [4*DIGITS-1:0]    o_Bcd,
  output logic                   o_Done,
  output logic                   o_Overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + SCORE_WIDTH;
  localparam int CNT_W = (SCORE_WIDTH > 1) ? $clog2(SCORE_WIDTH) : 1;

  // Clamp value follows DIGITS; when it cannot be exceeded by the input width the clamp is disabled.
  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;
  localparam bit CLAMP_EN = (SCORE_WIDTH < 64) && (MAX_VAL < (64'd1 << SCORE_WIDTH));
  localparam logic [63:0] MAX_VAL_64 = 64'(MAX_VAL);
  localparam logic [SCORE_WIDTH-1:0] MAX_W = MAX_VAL_64[SCORE_WIDTH-1:0];
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCORE_WIDTH - 1);

  bcd_state_e state_q, state_d;

  logic [SR_W-1:0]        sr_q, sr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clamp_q, clamp_d;
  logic                   pend_q, pend_d;
  logic [SCORE_WIDTH-1:0] pend_score_q, pend_score_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic                   ovf_q, ovf_d;
  logic                   done_q, done_d;

  logic [BCD_W-1:0]       adj_bcd;
  logic [SR_W-1:0]        shifted;
  logic [SCORE_WIDTH-1:0] load_score;
  logic [SCORE_WIDTH-1:0] load_val;
  logic                   load_over;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
        .i_Digit (sr_q[SCORE_WIDTH + 4*g +: 4]),
        .o_Digit (adj_bcd[4*g +: 4])
      );
    end
  endgenerate

  // adjusted BCD field above the untouched binary field, shifted left by one
  always_comb begin
    shifted = {adj_bcd[BCD_W-2:0], sr_q[SCORE_WIDTH-1:0], 1'b0};
  end

  // Load source (fresh request beats the pending entry) and its clamped value
  always_comb begin
    load_score = i_Valid ? i_Score : pend_score_q;
    load_val   = load_score;
    load_over  = 1'b0;
    if (CLAMP_EN && (load_score > MAX_W)) begin
      load_val  = MAX_W;
      load_over = 1'b1;
    end
  end

  // state register
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_Valid) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == LAST_CNT) state_d = ST_DONE;
      ST_DONE:  state_d = (i_Valid || pend_q) ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_Ready    = (state_q == ST_IDLE) && !pend_q;
    o_Bcd      = bcd_q;
    o_Done     = done_q;
    o_Overflow = ovf_q;
  end

  // datapath next values: shift register, counter, pending buffer, published result
  always_comb begin
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    clamp_d      = clamp_q;
    pend_d       = pend_q;
    pend_score_d = pend_score_q;
    bcd_d        = bcd_q;
    ovf_d        = ovf_q;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_Valid) begin
          sr_d    = {{BCD_W{1'b0}}, load_val};
          clamp_d = load_over;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        sr_d  = shifted;
        cnt_d = cnt_q + CNT_W'(1);
        if (i_Valid) begin
          pend_d       = 1'b1;
          pend_score_d = i_Score;
        end
      end
      ST_DONE: begin
        bcd_d  = sr_q[SR_W-1 -: BCD_W];
        ovf_d  = clamp_q;
        done_d = 1'b1;
        pend_d = 1'b0;
        cnt_d  = '0;
        if (i_Valid || pend_q) begin
          sr_d    = {{BCD_W{1'b0}}, load_val};
          clamp_d = load_over;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // datapath registers; reset discards any conversion in flight
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sr_q         <= '0;
      cnt_q        <= '0;
      clamp_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_score_q <= '0;
      bcd_q        <= '0;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      clamp_q      <= clamp_d;
      pend_q       <= pend_d;
      pend_score_q <= pend_score_d;
      bcd_q        <= bcd_d;
      ovf_q        <= ovf_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed bench for score_bcd_converter: vector table plus pending/reset sequences.
module tb_score_bcd_converter;

  logic        i_Clk;
  logic        i_Rst;
  logic [15:0] i_Score;
  logic        i_Valid;
  logic        o_Ready;
  logic [15:0] o_Bcd;
  logic        o_Done;
  logic        o_Overflow;

  int errors;
  int checks;

  score_bcd_converter dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Score    (i_Score),
    .i_Valid    (i_Valid),
    .o_Ready    (o_Ready),
    .o_Bcd      (o_Bcd),
    .o_Done     (o_Done),
    .o_Overflow (o_Overflow)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic [15:0] score;
    logic [15:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  // Wait for o_Done; returns edge count (or -1 on timeout) and whether o_Bcd
  // stayed at its prior value and o_Ready stayed low until then.
  task automatic wait_done(output int n, output bit stable, output bit busy);
    logic [15:0] prev;
    prev   = o_Bcd;
    stable = 1'b1;
    busy   = 1'b1;
    n      = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (o_Done) begin
        n = i;
        break;
      end
      if (o_Bcd !== prev) stable = 1'b0;
      if (o_Ready !== 1'b0) busy = 1'b0;
    end
  endtask

  task automatic start(input logic [15:0] s);
    i_Score = s;
    i_Valid = 1'b1;
    tick();
    i_Valid = 1'b0;
  endtask

  // Count o_Done pulses over a window of cycles
  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (o_Done) cnt++;
    end
  endtask

  initial begin
    vec_t vecs[8];
    int   n;
    int   cnt;
    bit   stable;
    bit   busy;

    errors = 0;
    checks = 0;
    vecs[0] = '{16'd1234,  16'h1234, 1'b0};
    vecs[1] = '{16'd0,     16'h0000, 1'b0};
    vecs[2] = '{16'd9999,  16'h9999, 1'b0};
    vecs[3] = '{16'd10000, 16'h9999, 1'b1};
    vecs[4] = '{16'd65535, 16'h9999, 1'b1};
    vecs[5] = '{16'd42,    16'h0042, 1'b0};
    vecs[6] = '{16'd5008,  16'h5008, 1'b0};
    vecs[7] = '{16'd7,     16'h0007, 1'b0};

    i_Rst   = 1'b1;
    i_Score = '0;
    i_Valid = 1'b0;
    tick();
    tick();
    check("reset_bcd",   o_Bcd, 16'h0000);
    check("reset_done",  o_Done, 0);
    check("reset_ovf",   o_Overflow, 0);
    check("reset_ready", o_Ready, 1);
    i_Rst = 1'b0;
    tick();

    // table-driven conversions
    for (int v = 0; v < 8; v++) begin
      start(vecs[v].score);
      check("ready_low_after_accept", o_Ready, 0);
      wait_done(n, stable, busy);
      check("latency", n, 17);
      check("bcd_stable_while_busy", stable, 1);
      check("ready_low_while_busy", busy, 1);
      check("bcd", o_Bcd, vecs[v].exp_bcd);
      check("ovf", o_Overflow, vecs[v].exp_ovf);
      check("ready_after_done", o_Ready, 1);
      tick();
      check("done_one_cycle", o_Done, 0);
      check("bcd_held", o_Bcd, vecs[v].exp_bcd);
    end

    // pending buffer, last write wins
    start(16'd100);
    tick();
    i_Score = 16'd200;
    i_Valid = 1'b1;
    tick();
    i_Valid = 1'b0;
    tick();
    i_Score = 16'd305;
    i_Valid = 1'b1;
    tick();
    i_Valid = 1'b0;
    i_Score = 16'd0;
    wait_done(n, stable, busy);
    check("pend_first_latency", n + 4, 17);
    check("pend_first_bcd", o_Bcd, 16'h0100);
    check("pend_ready_stays_low", o_Ready, 0);
    wait_done(n, stable, busy);
    check("pend_second_latency", n, 17);
    check("pend_ready_low_between", busy, 1);
    check("pend_second_bcd", o_Bcd, 16'h0305);
    check("pend_ready_after", o_Ready, 1);
    count_done(25, cnt);
    check("pend_no_third_done", cnt, 0);

    // simultaneous: fresh request in the DONE cycle beats the pending entry
    start(16'd5);
    i_Score = 16'd88;
    i_Valid = 1'b1;
    tick();
    i_Valid = 1'b0;
    for (int i = 2; i <= 16; i++) tick();
    check("sim_no_done_before_edge17", o_Done, 0);
    i_Score = 16'd77;
    i_Valid = 1'b1;
    tick();
    i_Valid = 1'b0;
    check("sim_done_edge17", o_Done, 1);
    check("sim_first_bcd", o_Bcd, 16'h0005);
    wait_done(n, stable, busy);
    check("sim_second_latency", n, 17);
    check("sim_second_bcd", o_Bcd, 16'h0077);
    check("sim_ready_after", o_Ready, 1);
    count_done(25, cnt);
    check("sim_pending_dropped", cnt, 0);

    // reset in the middle of a conversion
    start(16'd4321);
    for (int i = 1; i <= 6; i++) tick();
    i_Rst = 1'b1;
    tick();
    i_Rst = 1'b0;
    check("rst_mid_bcd", o_Bcd, 16'h0000);
    check("rst_mid_done", o_Done, 0);
    check("rst_mid_ready", o_Ready, 1);
    check("rst_mid_ovf", o_Overflow, 0);
    count_done(25, cnt);
    check("rst_mid_no_done", cnt, 0);
    start(16'd11);
    wait_done(n, stable, busy);
    check("rst_after_latency", n, 17);
    check("rst_after_bcd", o_Bcd, 16'h0011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
